// File: rtl/ro_measure_ctrl.sv
// -----------------------------------------------------------------------------
// ro_measure_ctrl
// Sequencer for the dual ring-oscillator measurement path. A run clears the
// RO edge counters, enables RO1 for a gate window of W = WIN_BASE << win_sel
// clk cycles, waits SETTLE cycles, captures the RO1 count, then repeats the
// sequence for RO2. It then publishes both counts, their signed difference,
// a faster-RO flag and a sticky saturation flag.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 level, sampled only while idle
//   cont                  restart automatically after results are published
//   abort                 synchronous abort back to idle (beats cont/DONE)
//   win_sel[1:0]          window select, latched when a run starts
//   ro_cnt_1/ro_cnt_2     RO edge counts, already synchronised to clk
//   ro_activate_1/2       registered RO enables, never high together
//   cnt_clr               one-cycle RO counter clear
//   busy                  high whenever the sequencer is not idle
//   done                  one-cycle pulse when the results update
//   result_1/result_2     captured counts
//   diff                  result_1 - result_2, CNT_W+1 bit two's complement
//   ro1_faster            result_1 > result_2
//   ovf                   a captured count was all-ones (sticky until start)
// -----------------------------------------------------------------------------
module ro_measure_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WIN_BASE = 256,
  parameter int SETTLE   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic [1:0]       win_sel,
  input  logic [CNT_W-1:0] ro_cnt_1,
  input  logic [CNT_W-1:0] ro_cnt_2,
  output logic             ro_activate_1,
  output logic             ro_activate_2,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result_1,
  output logic [CNT_W-1:0] result_2,
  output logic [CNT_W:0]   diff,
  output logic             ro1_faster,
  output logic             ovf
);

  localparam int WC_W = $clog2(WIN_BASE * 8) + 1;
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [WC_W-1:0]  WIN_BASE_W = WC_W'(WIN_BASE);
  localparam logic [WC_W-1:0]  WC_ONE     = {{(WC_W-1){1'b0}}, 1'b1};
  localparam logic [SC_W-1:0]  SET_LAST   = SC_W'(SETTLE - 1);
  localparam logic [SC_W-1:0]  SC_ONE     = {{(SC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_CLR1 = 4'd1;
  localparam logic [3:0] S_RUN1 = 4'd2;
  localparam logic [3:0] S_SET1 = 4'd3;
  localparam logic [3:0] S_CAP1 = 4'd4;
  localparam logic [3:0] S_CLR2 = 4'd5;
  localparam logic [3:0] S_RUN2 = 4'd6;
  localparam logic [3:0] S_SET2 = 4'd7;
  localparam logic [3:0] S_CAP2 = 4'd8;
  localparam logic [3:0] S_DONE = 4'd9;

  logic [3:0]       state_r;
  logic [3:0]       state_s;
  logic [1:0]       win_sel_r;
  logic [WC_W-1:0]  win_cnt_r;
  logic [WC_W-1:0]  win_last_s;
  logic [SC_W-1:0]  set_cnt_r;
  logic [CNT_W-1:0] cap1_r;
  logic [CNT_W-1:0] cap2_r;
  logic             latch_s;
  logic             publish_s;
  logic             sat_s;

  // Window length minus one, the reload value of the gate counter.
  assign win_last_s = (WIN_BASE_W << win_sel_r) - WC_ONE;
  // A new run begins from idle or by continuation; win_sel is sampled then.
  assign latch_s    = (state_s == S_CLR1) && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign publish_s  = (state_r == S_DONE) && !abort;
  assign sat_s      = (cap1_r == CNT_MAX) || (cap2_r == CNT_MAX);

  // Next-state logic; abort from any busy state wins over every other transition.
  always_comb begin
    state_s = state_r;
    if (abort && (state_r != S_IDLE)) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: state_s = start ? S_CLR1 : S_IDLE;
        S_CLR1: state_s = S_RUN1;
        S_RUN1: state_s = (win_cnt_r == {WC_W{1'b0}}) ? S_SET1 : S_RUN1;
        S_SET1: state_s = (set_cnt_r == {SC_W{1'b0}}) ? S_CAP1 : S_SET1;
        S_CAP1: state_s = S_CLR2;
        S_CLR2: state_s = S_RUN2;
        S_RUN2: state_s = (win_cnt_r == {WC_W{1'b0}}) ? S_SET2 : S_RUN2;
        S_SET2: state_s = (set_cnt_r == {SC_W{1'b0}}) ? S_CAP2 : S_SET2;
        S_CAP2: state_s = S_DONE;
        S_DONE: state_s = cont ? S_CLR1 : S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State register and window-select latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      win_sel_r <= 2'b00;
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        win_sel_r <= win_sel;
      end else begin
        win_sel_r <= win_sel_r;
      end
    end
  end

  // Gate counter reloads in CLRx so RUNx lasts W cycles; settle counter reloads during RUNx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_r <= {WC_W{1'b0}};
      set_cnt_r <= {SC_W{1'b0}};
    end else begin
      case (state_r)
        S_CLR1, S_CLR2: win_cnt_r <= win_last_s;
        S_RUN1, S_RUN2: begin
          win_cnt_r <= win_cnt_r - WC_ONE;
          set_cnt_r <= SET_LAST;
        end
        S_SET1, S_SET2: set_cnt_r <= set_cnt_r - SC_ONE;
        default: begin
          win_cnt_r <= win_cnt_r;
          set_cnt_r <= set_cnt_r;
        end
      endcase
    end
  end

  // Internal capture registers sampled after the settle interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap1_r <= {CNT_W{1'b0}};
      cap2_r <= {CNT_W{1'b0}};
    end else begin
      if (state_r == S_CAP1) begin
        cap1_r <= ro_cnt_1;
      end else begin
        cap1_r <= cap1_r;
      end
      if (state_r == S_CAP2) begin
        cap2_r <= ro_cnt_2;
      end else begin
        cap2_r <= cap2_r;
      end
    end
  end

  // Registered strobes; they trail the state by one cycle and drop at once on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_activate_1 <= 1'b0;
      ro_activate_2 <= 1'b0;
      cnt_clr       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      ro_activate_1 <= (state_r == S_RUN1) && !abort;
      ro_activate_2 <= (state_r == S_RUN2) && !abort;
      cnt_clr       <= ((state_r == S_CLR1) || (state_r == S_CLR2)) && !abort;
      busy          <= (state_s != S_IDLE);
      done          <= publish_s;
    end
  end

  // Published results change only in DONE; ovf additionally clears on a start from idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_1   <= {CNT_W{1'b0}};
      result_2   <= {CNT_W{1'b0}};
      diff       <= {(CNT_W+1){1'b0}};
      ro1_faster <= 1'b0;
      ovf        <= 1'b0;
    end else if (publish_s) begin
      result_1   <= cap1_r;
      result_2   <= cap2_r;
      diff       <= {1'b0, cap1_r} - {1'b0, cap2_r};
      ro1_faster <= (cap1_r > cap2_r);
      ovf        <= ovf | sat_s;
    end else if ((state_r == S_IDLE) && start) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf;
    end
  end

endmodule

// File: tb/tb_ro_measure_ctrl.sv
module tb_ro_measure_ctrl;

  localparam int CNT_W    = 16;
  localparam int WIN_BASE = 8;
  localparam int SETTLE   = 2;
  localparam int SATV     = 65535;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cont;
  logic        abort;
  logic [1:0]  win_sel;
  logic [15:0] ro_cnt_1;
  logic [15:0] ro_cnt_2;
  logic        ro_activate_1;
  logic        ro_activate_2;
  logic        cnt_clr;
  logic        busy;
  logic        done;
  logic [15:0] result_1;
  logic [15:0] result_2;
  logic [16:0] diff;
  logic        ro1_faster;
  logic        ovf;

  typedef struct {
    logic [15:0] r1;
    logic [15:0] r2;
    logic [16:0] d;
    logic        f;
    logic        o;
    time         ts;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int  n_chk   = 0;
  int  n_fail  = 0;
  int  rate1   = 0;
  int  rate2   = 0;
  int  exp_w   = WIN_BASE;
  bit  len_chk = 1'b1;
  bit  m_ovf   = 1'b0;
  int  last_r1 = 0;
  int  last_r2 = 0;
  time cur_ts  = 0;

  ro_measure_ctrl #(.CNT_W(CNT_W), .WIN_BASE(WIN_BASE), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
    .win_sel(win_sel), .ro_cnt_1(ro_cnt_1), .ro_cnt_2(ro_cnt_2),
    .ro_activate_1(ro_activate_1), .ro_activate_2(ro_activate_2),
    .cnt_clr(cnt_clr), .busy(busy), .done(done),
    .result_1(result_1), .result_2(result_2), .diff(diff),
    .ro1_faster(ro1_faster), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Ring-oscillator counters: clear on cnt_clr, add a fixed rate per enabled cycle, saturate.
  initial begin
    int c1;
    int c2;
    c1 = 0;
    c2 = 0;
    ro_cnt_1 = 16'd0;
    ro_cnt_2 = 16'd0;
    forever begin
      @(negedge clk);
      if (cnt_clr) begin
        c1 = 0;
        c2 = 0;
      end else begin
        if (ro_activate_1) c1 = (c1 + rate1 > SATV) ? SATV : c1 + rate1;
        if (ro_activate_2) c2 = (c2 + rate2 > SATV) ? SATV : c2 + rate2;
      end
      ro_cnt_1 = c1[15:0];
      ro_cnt_2 = c2[15:0];
    end
  end

  // Expected result of a run: count = rate * window, saturating; push to scoreboard.
  task automatic push_exp(input int ws, input time ts, input bit from_idle);
    exp_t e;
    int w;
    int e1;
    int e2;
    int dd;
    w  = WIN_BASE << ws;
    e1 = rate1 * w;
    e2 = rate2 * w;
    if (e1 > SATV) e1 = SATV;
    if (e2 > SATV) e2 = SATV;
    dd = e1 - e2;
    if (from_idle) m_ovf = 1'b0;
    m_ovf = m_ovf | (e1 == SATV) | (e2 == SATV);
    e.r1  = e1[15:0];
    e.r2  = e2[15:0];
    e.d   = dd[16:0];
    e.f   = (e1 > e2);
    e.o   = m_ovf;
    e.ts  = ts;
    e.lat = 2 * (w + SETTLE + 2) + 1;
    sb.push_back(e);
    last_r1 = e1;
    last_r2 = e2;
  endtask

  task automatic start_run(input int ws, input int ra, input int rb, output time ts);
    @(negedge clk);
    rate1   = ra;
    rate2   = rb;
    win_sel = ws[1:0];
    exp_w   = WIN_BASE << ws;
    start   = 1'b1;
    @(posedge clk);
    ts     = $time;
    cur_ts = ts;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int i;
    i = 0;
    while (sb.size() != 0 && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    chk("sb_drain", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(input int max_cyc);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!done && i < max_cyc);
    chk("wait_done", done, 1);
  endtask

  task automatic wait_act(input bit second, input int max_cyc);
    int i;
    i = 0;
    while (!(second ? ro_activate_2 : ro_activate_1) && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    chk("wait_enable", second ? ro_activate_2 : ro_activate_1, 1);
  endtask

  // Monitor: enable exclusivity, window lengths and edges, clear pulses, scoreboard pops.
  initial begin
    bit   p1;
    bit   p2;
    int   len1;
    int   len2;
    int   clr_cnt;
    exp_t e;
    p1 = 1'b0; p2 = 1'b0; len1 = 0; len2 = 0; clr_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p1 = 1'b0; p2 = 1'b0; len1 = 0; len2 = 0; clr_cnt = 0;
      end else begin
        chk("enable_overlap", {31'd0, ro_activate_1 & ro_activate_2}, 0);
        if (ro_activate_1) begin
          if (!p1 && len_chk) chk("act1_rise_cycle", int'(($time - 5 - cur_ts) / 10), 2);
          len1++;
        end else if (p1) begin
          if (len_chk) chk("act1_len", len1, exp_w);
          len1 = 0;
        end
        if (ro_activate_2) begin
          if (!p2 && len_chk)
            chk("act2_rise_cycle", int'(($time - 5 - cur_ts) / 10), 2 + exp_w + SETTLE + 2);
          len2++;
        end else if (p2) begin
          if (len_chk) chk("act2_len", len2, exp_w);
          len2 = 0;
        end
        p1 = ro_activate_1;
        p2 = ro_activate_2;
        if (cnt_clr) clr_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no pulse (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("done_latency", int'(($time - 5 - e.ts) / 10), e.lat);
            chk("result_1", result_1, e.r1);
            chk("result_2", result_2, e.r2);
            chk("diff", diff, e.d);
            chk("ro1_faster", ro1_faster, e.f);
            chk("ovf", ovf, e.o);
            chk("clr_pulses", clr_cnt, 2);
          end
          clr_cnt = 0;
        end
        if (!busy) clr_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time ts;
    int  ra;
    int  rb;
    int  ws;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; win_sel = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {busy, done, cnt_clr, ro_activate_1, ro_activate_2, ro1_faster, ovf}, 0);
    chk("rst_results", {result_1, result_2}, 0);
    chk("rst_diff", diff, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Basic run: 125 and 150 edges per cycle over an 8-cycle window.
    start_run(0, 125, 150, ts);
    push_exp(0, ts, 1'b1);
    drain(200);

    // Equal counts.
    start_run(1, 100, 100, ts);
    push_exp(1, ts, 1'b1);
    drain(200);

    // Largest window; win_sel changes mid-run must not alter it.
    start_run(3, 300, 7, ts);
    push_exp(3, ts, 1'b1);
    repeat (10) @(negedge clk);
    win_sel = 2'b00;
    drain(300);

    // Randomised runs.
    for (int k = 0; k < 6; k++) begin
      ws = $urandom_range(0, 3);
      ra = $urandom_range(0, 400);
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 400);
      start_run(ws, ra, rb, ts);
      push_exp(ws, ts, 1'b1);
      drain(300);
    end

    // Continuous mode: three back-to-back runs, then cont dropped.
    cont = 1'b1;
    start_run(0, 20, 30, ts);
    push_exp(0, ts, 1'b1);
    for (int k = 1; k < 3; k++) begin
      wait_done(100);
      cur_ts = $time - 5;
      rate1  = $urandom_range(0, 400);
      rate2  = $urandom_range(0, 400);
      push_exp(0, $time - 5, 1'b0);
      if (k == 2) cont = 1'b0;
    end
    drain(100);

    // Saturating RO2 count sets ovf, which survives idle.
    start_run(0, 50, 10000, ts);
    push_exp(0, ts, 1'b1);
    drain(200);
    chk("ovf_sticky_idle", ovf, 1);

    // New start clears ovf only; reset mid-RUN1 clears everything asynchronously.
    len_chk = 1'b0;
    start_run(0, 10, 10, ts);
    chk("ovf_clr_on_start", ovf, 0);
    chk("result_2_held", result_2, last_r2);
    wait_act(1'b0, 50);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {busy, done, cnt_clr, ro_activate_1, ro_activate_2, ro1_faster, ovf}, 0);
    chk("rst_mid_results", {result_1, result_2}, 0);
    chk("rst_mid_diff", diff, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_r1 = 0;
    last_r2 = 0;
    m_ovf   = 1'b0;
    repeat (2) @(negedge clk);
    len_chk = 1'b1;

    // Recovery run after reset.
    start_run(2, 60, 90, ts);
    push_exp(2, ts, 1'b1);
    drain(200);

    // Abort during RUN2: enables drop, idle, no done, results unchanged.
    len_chk = 1'b0;
    start_run(0, 5, 6, ts);
    wait_act(1'b1, 50);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_enables", {ro_activate_1, ro_activate_2, cnt_clr}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result_1", result_1, last_r1);
    chk("abort_result_2", result_2, last_r2);
    repeat (40) @(negedge clk);
    chk("abort_idle", busy, 0);
    len_chk = 1'b1;

    chk("sb_final_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
